alu_issue_stage: RTL

ID/EX boundary register that produces the operand/opcode bundle (ALUSel, A, B) consumed by the EX-stage ALU.
- Selects the A/B sources (register, shamt, immediate).
- Resolves RAW hazards by forwarding from the two downstream result taps.
- Detects load-use hazards and inserts one bubble.
- Honours a valid/ready handshake upstream and downstream, plus a flush from branch resolution.

---
 rtl/alu_issue_stage.sv | 102 ++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue register with operand forwarding and a load-use bubble.
// Define ALU_ISSUE_STATS_EN to add saturating hazard/flush/stall counters.
`ifndef WIDTH_ALUSEL
`define WIDTH_ALUSEL 4
`endif
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int SEL_W  = `WIDTH_ALUSEL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [SEL_W-1:0]  id_alusel,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [4:0]        id_shamt,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_srca_shamt,
  input  logic              id_srcb_imm,
  input  logic [REG_AW-1:0] id_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              f1_wr,
  input  logic              f2_wr,
  input  logic [REG_AW-1:0] f1_dst,
  input  logic [REG_AW-1:0] f2_dst,
  input  logic [DATA_W-1:0] f1_data,
  input  logic [DATA_W-1:0] f2_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [SEL_W-1:0]  ex_alusel,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [REG_AW-1:0] ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]       stat_hz_cnt,
  output logic [31:0]       stat_flush_cnt,
  output logic [31:0]       stat_stall_cnt
`endif
);
  logic [DATA_W-1:0] rs_fwd, rt_fwd, a_nxt, b_nxt;
  logic hz, accept;
  always_comb begin
    rs_fwd = (id_rs_addr == '0) ? '0 :
             (f1_wr && f1_dst == id_rs_addr) ? f1_data :
             (f2_wr && f2_dst == id_rs_addr) ? f2_data : id_rs_val;
    rt_fwd = (id_rt_addr == '0) ? '0 :
             (f1_wr && f1_dst == id_rt_addr) ? f1_data :
             (f2_wr && f2_dst == id_rt_addr) ? f2_data : id_rt_val;
    a_nxt  = id_srca_shamt ? {{(DATA_W-5){1'b0}}, id_shamt} : rs_fwd;
    b_nxt  = id_srcb_imm ? id_imm : rt_fwd;
    // Non-load results in EX are covered by the f1 tap; only a load must stall.
    hz     = ex_valid && ex_mem_read && ex_dst != '0 &&
             ((!id_srca_shamt && id_rs_addr == ex_dst) || (!id_srcb_imm && id_rt_addr == ex_dst));
    id_ready = (!ex_valid || ex_ready) && !hz && !flush;
    accept   = id_valid && id_ready;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_alusel    <= '0;
      ex_a         <= '0;
      ex_b         <= '0;
      ex_dst       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (flush || (ex_valid && ex_ready && !accept)) begin
      ex_valid     <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (accept) begin
      ex_valid     <= 1'b1;
      ex_alusel    <= id_alusel;
      ex_a         <= a_nxt;
      ex_b         <= b_nxt;
      ex_dst       <= id_dst;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
    end
  end
`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hz_cnt    <= '0;
      stat_flush_cnt <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (hz && id_valid && ~&stat_hz_cnt) stat_hz_cnt <= stat_hz_cnt + 32'd1;
      if (flush && ex_valid && ~&stat_flush_cnt) stat_flush_cnt <= stat_flush_cnt + 32'd1;
      if (ex_valid && !ex_ready && ~&stat_stall_cnt) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
